// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and fetch datapath constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect beats sequential increment, which beats hold.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_inc_base,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // Redirect targets are forced word aligned; the increment wraps modulo 2^ADDR_W.
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect) begin
            w_pc_next = i_redirect_pc & ~ADDR_W'(3);
        end else if (i_inc) begin
            w_pc_next = i_inc_base + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues imem requests, holds the fetched word for the decoder,
// and discards responses that a branch/jump redirect has made stale.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] read_data,
    output logic               read_valid,
    output logic [ADDR_W-1:0]  pc_out
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic               r_gap;
    logic               w_gap_next;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [INSTR_W-1:0] r_read_data;
    logic               r_read_valid;
    logic [ADDR_W-1:0]  r_pc_out;
    logic               w_deliver;
    logic               w_load_req;
    logic               w_release;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_pc_next;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_inc         (w_deliver),
        .i_inc_base    (r_req_addr),
        .o_pc          (w_pc),
        .o_pc_next     (w_pc_next)
    );

    // r_gap marks the one idle cycle in S_REQ after an acked request was killed by a redirect.
    always_comb begin
        w_state_next = r_state;
        w_gap_next   = 1'b0;
        w_deliver    = 1'b0;
        w_load_req   = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                w_load_req   = 1'b1;
            end
            S_REQ: begin
                if (r_gap) begin
                    w_load_req = 1'b1;
                end else if (imem_ack) begin
                    if (redirect) begin
                        w_gap_next = 1'b1;
                    end else begin
                        w_deliver    = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end else if (redirect) begin
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    w_state_next = S_IDLE;
                end
            end
            S_HOLD: begin
                if (redirect || dec_ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_gap   <= w_gap_next;
        end
    end

    // The request address is captured from the post-redirect PC so an IDLE-cycle redirect wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_addr <= RESET_PC;
        end else if (w_load_req) begin
            r_req_addr <= w_pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_read_data  <= '0;
            r_pc_out     <= '0;
            r_read_valid <= 1'b0;
        end else begin
            if (w_deliver) begin
                r_read_data  <= imem_rdata;
                r_pc_out     <= r_req_addr;
                r_read_valid <= 1'b1;
            end else if (w_release) begin
                r_read_valid <= 1'b0;
            end
        end
    end

    assign imem_req   = ((r_state == S_REQ) && !r_gap) || (r_state == S_DROP);
    assign imem_addr  = r_req_addr;
    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign pc_out     = r_pc_out;

    logic w_unused;
    assign w_unused = ^w_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized phase,
// all compared against a transaction-level model of the fetch stage.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic [31:0] read_data;
    logic        read_valid;
    logic [31:0] pc_out;

    logic        w_req2;
    logic [31:0] w_addr2;
    logic [31:0] w_rd2;
    logic        w_rv2;
    logic [31:0] w_pc2;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready),
        .read_data(read_data), .read_valid(read_valid), .pc_out(pc_out)
    );

    // Second instance starting at the top of the address space, with a zero-wait memory.
    instr_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req2), .imem_addr(w_addr2),
        .imem_ack(w_req2), .imem_rdata(~w_addr2),
        .redirect(1'b0), .redirect_pc(32'h0),
        .dec_ready(1'b1),
        .read_data(w_rd2), .read_valid(w_rv2), .pc_out(w_pc2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a request is either on the bus, an instruction is held, or the stage
    // is in a one-cycle bubble before the next request.
    logic        m_req_on;
    logic        m_discard;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [31:0] m_data;
    logic [31:0] m_pcout;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req_on  = 1'b0;
        m_discard = 1'b0;
        m_valid   = 1'b0;
        m_addr    = 32'h0;
        m_pc      = 32'h0;
        m_data    = 32'h0;
        m_pcout   = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] rp;
        rp = {redirect_pc[31:2], 2'b00};
        if (m_req_on) begin
            if (imem_ack) begin
                m_req_on = 1'b0;
                if (m_discard) begin
                    m_discard = 1'b0;
                end else if (!redirect) begin
                    m_valid = 1'b1;
                    m_data  = imem_rdata;
                    m_pcout = m_addr;
                    m_pc    = m_addr + 32'd4;
                end
            end else if (redirect) begin
                m_discard = 1'b1;
            end
            if (redirect) m_pc = rp;
        end else if (m_valid) begin
            if (redirect || dec_ready) m_valid = 1'b0;
            if (redirect) m_pc = rp;
        end else begin
            if (redirect) m_pc = rp;
            m_req_on = 1'b1;
            m_addr   = m_pc;
        end
    endtask

    task automatic compare();
        chk("imem_req", imem_req, m_req_on);
        chk("read_valid", read_valid, m_valid);
        if (m_req_on) chk("imem_addr", imem_addr, m_addr);
        if (m_valid) begin
            chk("read_data", read_data, m_data);
            chk("pc_out", pc_out, m_pcout);
        end
    endtask

    // Called at a negedge; drives inputs, advances one clock, checks #1 after the edge.
    task automatic step(input logic ack, input logic [31:0] rd, input logic rdir,
                        input logic [31:0] rpc, input logic rdy);
        imem_ack    = ack;
        imem_rdata  = rd;
        redirect    = rdir;
        redirect_pc = rpc;
        dec_ready   = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!m_req_on && n < 10) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            n++;
        end
        chk("wait_req", imem_req, 1'b1);
    endtask

    initial begin
        logic [31:0] exp_pcs [3];
        int got;
        int delivered;
        exp_pcs = '{32'h0, 32'h4, 32'h8};

        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
        redirect_pc = 32'h0; dec_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", read_valid, 1'b0);
        chk("rst_data", read_data, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        rst = 1'b0;

        // Sequential fetch with immediate acks and an always-ready decoder.
        got = 0;
        for (int c = 0; c < 30 && got < 3; c++) begin
            step(m_req_on, mem(m_addr), 1'b0, 32'h0, 1'b1);
            if (m_valid) begin
                chk("t1_pc_out", pc_out, exp_pcs[got]);
                chk("t1_data", read_data, mem(exp_pcs[got]));
                got++;
            end
        end
        chk("t1_count", got, 3);

        // Decoder stall holds the instruction and blocks new requests.
        wait_req();
        step(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, $urandom, 1'b0, 32'h0, 1'b0);
            chk("t2_valid", read_valid, 1'b1);
            chk("t2_data", read_data, 32'h1234_5678);
            chk("t2_req", imem_req, 1'b0);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Redirect while a slow request is outstanding.
        step(1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
        chk("t3_addr0", imem_addr, 32'h10);
        step(1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        chk("t3_req1", imem_req, 1'b1);
        chk("t3_addr1", imem_addr, 32'h10);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t3_addr2", imem_addr, 32'h10);
        step(1'b1, 32'hDEAD_0010, 1'b0, 32'h0, 1'b1);
        chk("t3_dropped", read_valid, 1'b0);
        chk("t3_bubble", imem_req, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t3_next", imem_addr, 32'h80);

        // Redirect in the ack cycle.
        step(1'b1, 32'hBEEF_0080, 1'b1, 32'h40, 1'b1);
        chk("t4_valid", read_valid, 1'b0);
        chk("t4_req_gap", imem_req, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t4_req", imem_req, 1'b1);
        chk("t4_addr", imem_addr, 32'h40);

        // Redirect with dec_ready in HOLD, then two redirects while dropping.
        step(1'b1, mem(32'h40), 1'b0, 32'h0, 1'b0);
        chk("t5_pc_out", pc_out, 32'h40);
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
        chk("t5_consumed", read_valid, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t5_addr", imem_addr, 32'h100);
        step(1'b0, 32'h0, 1'b1, 32'h20, 1'b1);
        step(1'b1, 32'h5555_AAAA, 1'b1, 32'h33, 1'b1);
        chk("t5_drop_valid", read_valid, 1'b0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t5_last_wins", imem_addr, 32'h30);

        // Asynchronous reset while waiting on an ack at 0x8.
        step(1'b1, 32'h0, 1'b1, 32'h8, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("t6_addr8", imem_addr, 32'h8);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req", imem_req, 1'b0);
        chk("t6_valid", read_valid, 1'b0);
        chk("t6_addr", imem_addr, 32'h0);
        chk("t6_pc_out", pc_out, 32'h0);
        chk("t6_data", read_data, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 32'h0BAD_0BAD, 1'b0, 32'h0, 1'b1);
        chk("t6_late_ack", read_valid, 1'b0);
        chk("t6_restart", imem_addr, 32'h0);
        chk("wrap_req", w_req2, 1'b1);
        chk("wrap_addr", w_addr2, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("wrap_valid", w_rv2, 1'b1);
        chk("wrap_pc_out", w_pc2, 32'hFFFF_FFFC);
        chk("wrap_data", w_rd2, 32'h0000_0003);
        step(m_req_on, mem(m_addr), 1'b0, 32'h0, 1'b1);
        step(m_req_on, mem(m_addr), 1'b0, 32'h0, 1'b1);
        chk("wrap_next_req", w_req2, 1'b1);
        chk("wrap_next_addr", w_addr2, 32'h0);

        // Randomized traffic against the model.
        delivered = 0;
        for (int c = 0; c < 800; c++) begin
            logic a;
            a = m_req_on ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            step(a, $urandom, ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 2) != 0));
            if (m_valid) delivered++;
        end
        chk("rand_progress", (delivered != 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
